alu_result_uart_tx: RTL

- Transmit end for the ALU result path. Accepts one ALU/adder result (8-bit sum plus carry-out) through a valid/ready handshake and serialises it as an asynchronous UART-style frame on a single pin.
- Sits between the ALU/prefix-adder outputs and one dedicated output pin of the TinyTapeout top. An external receiver reads the result serially instead of through eight parallel pins.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_tx_baud_cnt.sv | 30 +++
 rtl/alu_result_uart_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
// Parity support in the transmitter is selected with the ALU_TX_PARITY_EN macro.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // res_data[7:0] followed by res_cout
    localparam int   TX_DATA_BITS  = 9;
    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/alu_tx_baud_cnt.sv
// Bit-period counter for the result transmitter: counts 0..CLKS_PER_BIT-1 and
// raises tick on the last cycle of each bit period.
module alu_tx_baud_cnt #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == CNT_MAX) ? '0 : count + CNT_W'(1);
        end
    end

    assign tick = en && (count == CNT_MAX);

endmodule

// File: rtl/alu_result_uart_tx.sv
// Serialises one ALU result (8-bit sum + carry-out) as a UART-style frame on tx.
// Define ALU_TX_PARITY_EN to insert an even-parity bit after the carry-out bit.
module alu_result_uart_tx
    import alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] res_data,
    input  logic       res_cout,
    input  logic       res_valid,
    output logic       res_ready,
    output logic       tx,
    output logic       busy
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("alu_result_uart_tx: CLKS_PER_BIT must be 2 or more");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("alu_result_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int                    BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0]  LAST_DATA = BIT_CNT_W'(TX_DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    // Handshake: a result transfers on a rising edge where res_valid && res_ready.
    // res_ready is only ever high in IDLE, so res_valid is ignored mid-frame.
    tx_state_t               state, state_nxt;
    logic [TX_DATA_BITS-1:0] shift_q, shift_nxt;
    logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic                    tx_nxt, busy_nxt, ready_nxt;
    logic                    accept, tick;
`ifdef ALU_TX_PARITY_EN
    logic                    par_q, par_nxt;
`endif

    assign accept = (state == IDLE) && res_valid && res_ready;

    alu_tx_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            tx        <= TX_IDLE_LEVEL;
            busy      <= 1'b0;
            res_ready <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
            res_ready <= ready_nxt;
`ifdef ALU_TX_PARITY_EN
            par_q     <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = tx;
        busy_nxt    = busy;
        ready_nxt   = 1'b0;
`ifdef ALU_TX_PARITY_EN
        par_nxt     = par_q;
`endif
        case (state)
            IDLE: begin
                tx_nxt    = TX_IDLE_LEVEL;
                busy_nxt  = 1'b0;
                ready_nxt = ena;
                if (accept) begin
                    state_nxt   = START;
                    shift_nxt   = {res_cout, res_data};
                    bit_cnt_nxt = '0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    ready_nxt   = 1'b0;
`ifdef ALU_TX_PARITY_EN
                    par_nxt     = ^{res_cout, res_data};
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_nxt = '0;
`ifdef ALU_TX_PARITY_EN
                        state_nxt   = PARITY;
                        tx_nxt      = par_q;
`else
                        state_nxt   = STOP;
                        tx_nxt      = TX_IDLE_LEVEL;
`endif
                    end else begin
                        shift_nxt   = {1'b0, shift_q[TX_DATA_BITS-1:1]};
                        tx_nxt      = shift_q[1];
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef ALU_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_nxt   = STOP;
                    tx_nxt      = TX_IDLE_LEVEL;
                    bit_cnt_nxt = '0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        // res_ready is raised on the same edge that returns to IDLE so a
                        // held res_valid starts the next frame one cycle after the stop period.
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        ready_nxt = ena;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = TX_IDLE_LEVEL;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
